// File: rtl/spike_window_counter.sv
// ---------------------------------------------------------------------------
// spike_window_counter
//
// Purpose:
//   Sits downstream of the SNN output layer and counts spikes per output
//   neuron over a window of N delay_clk ticks. When a window completes, the
//   per-neuron totals are latched into a result register and offered to a
//   consumer (SPI readback / debug path) through a valid/ack handshake.
//   Everything runs on clk; delay_clk is from the same clock domain and is
//   used only as a tick source (its rising edge marks one timestep).
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   enable         run counting; low returns to idle and clears working counters
//   delay_clk      timestep clock, rising edge = one tick
//   window_len     ticks per window (0 is treated as 1)
//   output_spikes  spike vector from the SNN output layer
//   counts_out     latched counts, neuron i at [i*COUNT_WIDTH +: COUNT_WIDTH]
//   counts_valid   counts_out holds an unacknowledged window result
//   counts_ack     consumer has taken counts_out
//   overrun        sticky: a window completed while a result was still pending
//   overflow       sticky per-neuron counter overflow flag
//
// Configuration macro:
//   SPIKE_COUNT_SATURATE_EN  defined   -> counters saturate at all-ones
//                            undefined -> counters wrap to zero
//   Either way overflow[i] sets when an increment is attempted at all-ones.
// ---------------------------------------------------------------------------
module spike_window_counter #(
  parameter int NUM_OUTPUTS  = 2,
  parameter int COUNT_WIDTH  = 8,
  parameter int WINDOW_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               delay_clk,
  input  logic [WINDOW_WIDTH-1:0]            window_len,
  input  logic [NUM_OUTPUTS-1:0]             output_spikes,
  output logic [NUM_OUTPUTS*COUNT_WIDTH-1:0] counts_out,
  output logic                               counts_valid,
  input  logic                               counts_ack,
  output logic                               overrun,
  output logic [NUM_OUTPUTS-1:0]             overflow
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [COUNT_WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [COUNT_WIDTH-1:0]  CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [WINDOW_WIDTH-1:0] WIN_ONE  = WINDOW_WIDTH'(1);
  localparam logic [WINDOW_WIDTH:0]   TICK_ONE = (WINDOW_WIDTH + 1)'(1);

  state_t                            state;
  state_t                            state_next;
  logic                              delay_clk_q;
  logic                              tick;
  logic [WINDOW_WIDTH-1:0]           win_len_q;
  logic [WINDOW_WIDTH-1:0]           win_len_eff;
  logic [WINDOW_WIDTH-1:0]           tick_cnt;
  logic [WINDOW_WIDTH:0]             tick_cnt_inc;
  logic [COUNT_WIDTH-1:0]            cnt      [NUM_OUTPUTS];
  logic [COUNT_WIDTH-1:0]            cnt_next [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0]            ovf_hit;
  logic [NUM_OUTPUTS*COUNT_WIDTH-1:0] final_counts;
  logic                              counting;
  logic                              window_end;
  logic                              load_result;

  // Rising-edge detect on delay_clk; delay_clk_q is sampled every cycle so
  // that an edge seen while idle is not replayed when counting starts.
  assign tick = delay_clk & ~delay_clk_q;

  // A zero window length would never complete, so it is promoted to 1.
  assign win_len_eff = (window_len == '0) ? WIN_ONE : window_len;

  // One extra bit keeps the end-of-window compare exact at the top of range.
  assign tick_cnt_inc = {1'b0, tick_cnt} + TICK_ONE;

  assign counting    = (state == COUNT) && enable;
  assign window_end  = counting && tick && (tick_cnt_inc == {1'b0, win_len_q});

  // A finished window may overwrite the result register only if it is empty
  // or the consumer is acknowledging the old result in this very cycle.
  assign load_result = window_end && (!counts_valid || counts_ack);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: enable alone moves between idle and counting.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable)  state_next = COUNT;
      COUNT:   if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-neuron increment including the current tick's spike, and the packed
  // view of those values used as the final result at a window end.
  always_comb begin
    final_counts = '0;
    ovf_hit      = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      cnt_next[i] = cnt[i];
      if (output_spikes[i]) begin
        if (cnt[i] == CNT_MAX) begin
          ovf_hit[i] = 1'b1;
`ifdef SPIKE_COUNT_SATURATE_EN
          cnt_next[i] = CNT_MAX;
`else
          cnt_next[i] = '0;
`endif
        end else begin
          cnt_next[i] = cnt[i] + CNT_ONE;
        end
      end
      final_counts[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt_next[i];
    end
  end

  // Working counters, window bookkeeping, result register and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      delay_clk_q  <= 1'b0;
      win_len_q    <= '0;
      tick_cnt     <= '0;
      counts_out   <= '0;
      counts_valid <= 1'b0;
      overrun      <= 1'b0;
      overflow     <= '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      delay_clk_q <= delay_clk;

      if (state == IDLE) begin
        tick_cnt <= '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
          cnt[i] <= '0;
        end
        if (enable) begin
          win_len_q <= win_len_eff;
        end
      end else if (!enable) begin
        tick_cnt <= '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
          cnt[i] <= '0;
        end
      end else if (tick) begin
        overflow <= overflow | ovf_hit;
        if (window_end) begin
          // Window length is re-sampled only here, so mid-window changes
          // wait for the next window.
          tick_cnt  <= '0;
          win_len_q <= win_len_eff;
          for (int i = 0; i < NUM_OUTPUTS; i++) begin
            cnt[i] <= '0;
          end
          if (load_result) begin
            counts_out <= final_counts;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          tick_cnt <= tick_cnt + WIN_ONE;
          for (int i = 0; i < NUM_OUTPUTS; i++) begin
            cnt[i] <= cnt_next[i];
          end
        end
      end

      // New data wins over an acknowledge in the same cycle.
      if (load_result) begin
        counts_valid <= 1'b1;
      end else if (counts_ack) begin
        counts_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_window_counter.sv
// ---------------------------------------------------------------------------
// tb_spike_window_counter
//
// Drives two instances of spike_window_counter from the same inputs: one with
// 8-bit counters and one with 2-bit counters so that overflow behaviour is
// reachable. A behavioural model tracks true (unbounded) spike totals per
// window and folds them into the counter width only when a result is latched.
// Outputs of both instances are compared against the model on every falling
// edge, and a few directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_spike_window_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        delay_clk;
  logic [7:0]  window_len;
  logic [1:0]  output_spikes;
  logic        counts_ack;

  logic [15:0] counts_out_b;
  logic        counts_valid_b;
  logic        overrun_b;
  logic [1:0]  overflow_b;

  logic [3:0]  counts_out_s;
  logic        counts_valid_s;
  logic        overrun_s;
  logic [1:0]  overflow_s;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  spike_window_counter #(
    .NUM_OUTPUTS (2),
    .COUNT_WIDTH (8),
    .WINDOW_WIDTH(8)
  ) dut_big (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .delay_clk    (delay_clk),
    .window_len   (window_len),
    .output_spikes(output_spikes),
    .counts_out   (counts_out_b),
    .counts_valid (counts_valid_b),
    .counts_ack   (counts_ack),
    .overrun      (overrun_b),
    .overflow     (overflow_b)
  );

  spike_window_counter #(
    .NUM_OUTPUTS (2),
    .COUNT_WIDTH (2),
    .WINDOW_WIDTH(8)
  ) dut_small (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .delay_clk    (delay_clk),
    .window_len   (window_len),
    .output_spikes(output_spikes),
    .counts_out   (counts_out_s),
    .counts_valid (counts_valid_s),
    .counts_ack   (counts_ack),
    .overrun      (overrun_s),
    .overflow     (overflow_s)
  );

  // Reduce a true spike total to what a counter of width w must show.
  function automatic int fold(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
`ifdef SPIKE_COUNT_SATURATE_EN
    return (n > mx) ? mx : n;
`else
    return n % (mx + 1);
`endif
  endfunction

  // Behavioural model state.
  bit          m_run;
  bit          m_prev;
  bit          m_tick;
  bit          m_loaded;
  int          m_ticks;
  int          m_len;
  int          m_n [2];
  logic [15:0] m_out_b = '0;
  logic [3:0]  m_out_s = '0;
  logic        m_valid = 1'b0;
  logic        m_overrun = 1'b0;
  logic [1:0]  m_ovf_b = '0;
  logic [1:0]  m_ovf_s = '0;

  // Model update: windows are counted as plain integers; a window closes on
  // the m_len-th rising edge of delay_clk seen while running.
  always @(posedge clk) begin
    m_tick   = delay_clk && !m_prev;
    m_loaded = 1'b0;
    if (reset) begin
      m_prev    = 1'b0;
      m_run     = 1'b0;
      m_ticks   = 0;
      m_len     = 1;
      m_n[0]    = 0;
      m_n[1]    = 0;
      m_out_b   = '0;
      m_out_s   = '0;
      m_valid   = 1'b0;
      m_overrun = 1'b0;
      m_ovf_b   = '0;
      m_ovf_s   = '0;
    end else begin
      m_prev = delay_clk;
      if (!m_run) begin
        m_n[0] = 0;
        m_n[1] = 0;
        if (enable) begin
          m_run   = 1'b1;
          m_ticks = 0;
          m_len   = (window_len == 0) ? 1 : int'(window_len);
        end
      end else if (!enable) begin
        m_run   = 1'b0;
        m_ticks = 0;
        m_n[0]  = 0;
        m_n[1]  = 0;
      end else if (m_tick) begin
        for (int i = 0; i < 2; i++) begin
          if (output_spikes[i]) begin
            m_n[i]++;
            if (m_n[i] > 3)   m_ovf_s[i] = 1'b1;
            if (m_n[i] > 255) m_ovf_b[i] = 1'b1;
          end
        end
        m_ticks++;
        if (m_ticks == m_len) begin
          if (!m_valid || counts_ack) begin
            for (int i = 0; i < 2; i++) begin
              m_out_b[i*8 +: 8] = 8'(fold(m_n[i], 8));
              m_out_s[i*2 +: 2] = 2'(fold(m_n[i], 2));
            end
            m_loaded = 1'b1;
          end else begin
            m_overrun = 1'b1;
          end
          m_n[0]  = 0;
          m_n[1]  = 0;
          m_ticks = 0;
          m_len   = (window_len == 0) ? 1 : int'(window_len);
        end
      end
      if (m_loaded) m_valid = 1'b1;
      else if (counts_ack) m_valid = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Continuous comparison of both instances against the model.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("big.counts_out",     32'(counts_out_b),   32'(m_out_b));
      checkOutput("big.counts_valid",   32'(counts_valid_b), 32'(m_valid));
      checkOutput("big.overrun",        32'(overrun_b),      32'(m_overrun));
      checkOutput("big.overflow",       32'(overflow_b),     32'(m_ovf_b));
      checkOutput("small.counts_out",   32'(counts_out_s),   32'(m_out_s));
      checkOutput("small.counts_valid", 32'(counts_valid_s), 32'(m_valid));
      checkOutput("small.overrun",      32'(overrun_s),      32'(m_overrun));
      checkOutput("small.overflow",     32'(overflow_s),     32'(m_ovf_s));
    end
  end

  // Drive one cycle's worth of inputs, then advance to the next falling edge.
  task automatic applyStimulus(input logic dclk, input logic [1:0] spikes,
                               input logic ack);
    delay_clk     = dclk;
    output_spikes = spikes;
    counts_ack    = ack;
    @(negedge clk);
  endtask

  // One delay_clk tick: high for a cycle (edge), then low for a cycle.
  task automatic doTick(input logic [1:0] spikes, input logic ack);
    applyStimulus(1'b1, spikes, ack);
    applyStimulus(1'b0, 2'b00, 1'b0);
  endtask

  task automatic doReset();
    reset  = 1'b1;
    enable = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0);
    reset  = 1'b0;
  endtask

  task automatic startWindow(input logic [7:0] len);
    window_len = len;
    enable     = 1'b1;
    applyStimulus(1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    enable        = 1'b0;
    delay_clk     = 1'b0;
    window_len    = 8'd4;
    output_spikes = 2'b00;
    counts_ack    = 1'b0;
    @(negedge clk);
    check_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Reset state, and ticks while disabled produce nothing.
    checkOutput("reset.counts_out", 32'(counts_out_b), 32'h0);
    checkOutput("reset.valid",      32'(counts_valid_b), 32'h0);
    checkOutput("reset.flags",      32'({overrun_b, overflow_b, overflow_s}), 32'h0);
    for (int k = 0; k < 3; k++) doTick(2'b11, 1'b0);
    checkOutput("idle.valid", 32'(counts_valid_b), 32'h0);

    // Window of 4: neuron0 every tick, neuron1 on tick 2 only.
    startWindow(8'd4);
    doTick(2'b01, 1'b0);
    doTick(2'b11, 1'b0);
    doTick(2'b01, 1'b0);
    doTick(2'b01, 1'b0);
    checkOutput("win4.counts_out", 32'(counts_out_b), 32'h0104);
    checkOutput("win4.valid",      32'(counts_valid_b), 32'h1);

    // Second window without ack: dropped, overrun set.
    for (int k = 0; k < 4; k++) doTick(2'b11, 1'b0);
    checkOutput("overrun.flag",       32'(overrun_b), 32'h1);
    checkOutput("overrun.counts_out", 32'(counts_out_b), 32'h0104);
    applyStimulus(1'b0, 2'b00, 1'b1);
    checkOutput("ack.valid", 32'(counts_valid_b), 32'h0);

    // Ack coinciding with window end keeps valid and loads new counts.
    for (int k = 0; k < 4; k++) doTick(2'b11, 1'b0);
    checkOutput("full.counts_out", 32'(counts_out_b), 32'h0404);
    for (int k = 0; k < 3; k++) doTick(2'b10, 1'b0);
    doTick(2'b10, 1'b1);
    checkOutput("ackend.valid",      32'(counts_valid_b), 32'h1);
    checkOutput("ackend.counts_out", 32'(counts_out_b), 32'h0400);
    applyStimulus(1'b0, 2'b00, 1'b1);

    // Window length 0 behaves as 1: every tick yields {1,1}.
    doReset();
    startWindow(8'd0);
    for (int k = 0; k < 3; k++) begin
      doTick(2'b11, 1'b0);
      checkOutput("len0.counts_out", 32'(counts_out_b), 32'h0101);
      checkOutput("len0.valid",      32'(counts_valid_b), 32'h1);
      applyStimulus(1'b0, 2'b00, 1'b1);
      checkOutput("len0.acked", 32'(counts_valid_b), 32'h0);
    end
    checkOutput("len0.overrun", 32'(overrun_b), 32'h0);

    // Six spikes into a 2-bit counter.
    doReset();
    checkOutput("small.reset_ovf", 32'(overflow_s), 32'h0);
    startWindow(8'd6);
    for (int k = 0; k < 6; k++) doTick(2'b01, 1'b0);
`ifdef SPIKE_COUNT_SATURATE_EN
    checkOutput("small.count6", 32'(counts_out_s[1:0]), 32'h3);
`else
    checkOutput("small.count6", 32'(counts_out_s[1:0]), 32'h2);
`endif
    checkOutput("small.ovf6",  32'(overflow_s), 32'h1);
    checkOutput("big.count6",  32'(counts_out_b), 32'h0006);
    checkOutput("big.ovf6",    32'(overflow_b), 32'h0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      reset  = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 9) == 0) window_len = 8'($urandom_range(0, 7));
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 3) == 0));
    end
    reset = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
